// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM macro bus controller.
// Holds the FSM encoding and the byte-strobe to bit-enable expansion.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [31:0] WEN_NONE = 32'hFFFF_FFFF;

    // Active-low per-bit enable: a set strobe pulls its 8 bits low.
    function automatic logic [31:0] strb2wen(input logic [3:0] strb);
        strb2wen = ~{{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/sram_bus_ctrl.sv
// Native valid/ready bus to single-port SRAM macro bridge.
// Includes an optional post-reset clear sweep and an RDY watchdog.
module sram_bus_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW             = 14,
    parameter int CLEAR_ON_RESET = 0,
    parameter int TIMEOUT        = 15
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_rdata,
    output logic          mem_err,
    output logic          clr_busy,
    output logic [AW-1:0] sram_A,
    output logic [31:0]   sram_D,
    output logic          sram_CEn,
    output logic [31:0]   sram_WEn,
    input  logic [31:0]   sram_Q,
    input  logic          sram_RDY
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLR : ST_IDLE;
    localparam logic [AW-1:0] A_LAST = {AW{1'b1}};
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t        r_state;
    logic          r_ready;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_busy;
    logic [AW-1:0] r_a;
    logic [31:0]   r_d;
    logic          r_cen;
    logic [31:0]   r_wen;
    logic          r_is_read;
    logic [CW-1:0] r_cnt;

    state_t        w_state;
    logic          w_ready;
    logic [31:0]   w_rdata;
    logic          w_err;
    logic          w_busy;
    logic [AW-1:0] w_a;
    logic [31:0]   w_d;
    logic          w_cen;
    logic [31:0]   w_wen;
    logic          w_is_read;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_unused;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_unused  = &{1'b0, mem_addr[31:AW+2], mem_addr[1:0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= RST_STATE;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_a       <= '0;
            r_d       <= '0;
            r_cen     <= 1'b1;
            r_wen     <= WEN_NONE;
            r_is_read <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_ready   <= w_ready;
            r_rdata   <= w_rdata;
            r_err     <= w_err;
            r_busy    <= w_busy;
            r_a       <= w_a;
            r_d       <= w_d;
            r_cen     <= w_cen;
            r_wen     <= w_wen;
            r_is_read <= w_is_read;
            r_cnt     <= w_cnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ready   = r_ready;
        w_rdata   = r_rdata;
        w_err     = r_err;
        w_busy    = r_busy;
        w_a       = r_a;
        w_d       = r_d;
        w_cen     = r_cen;
        w_wen     = r_wen;
        w_is_read = r_is_read;
        w_cnt     = r_cnt;
        unique case (r_state)
            ST_CLR: begin
                // First CLR edge arms the sweep; busy marks it running.
                if (!r_busy) begin
                    w_busy = 1'b1;
                    w_cen  = 1'b0;
                    w_wen  = '0;
                    w_d    = '0;
                    w_a    = '0;
                end else if (r_a == A_LAST) begin
                    w_busy  = 1'b0;
                    w_cen   = 1'b1;
                    w_wen   = WEN_NONE;
                    w_state = ST_IDLE;
                end else begin
                    w_a = r_a + AW'(1);
                end
            end
            ST_IDLE: begin
                if (mem_valid && !r_ready) begin
                    w_a       = mem_addr[AW+1:2];
                    w_d       = mem_wdata;
                    w_wen     = strb2wen(mem_wstrb);
                    w_cen     = 1'b0;
                    w_is_read = (mem_wstrb == 4'b0000);
                    w_state   = ST_CMD;
                end
            end
            ST_CMD: begin
                // Enable stays low one more edge; make that edge a read.
                w_wen   = WEN_NONE;
                w_cnt   = '0;
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (sram_RDY) begin
                    if (r_is_read) begin
                        w_rdata = sram_Q;
                    end
                    w_ready = 1'b1;
                    w_cen   = 1'b1;
                    w_state = ST_RESP;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX) begin
                        w_rdata = '0;
                        w_err   = 1'b1;
                        w_ready = 1'b1;
                        w_cen   = 1'b1;
                        w_state = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                w_ready = 1'b0;
                w_err   = 1'b0;
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign mem_err   = r_err;
    assign clr_busy  = r_busy;
    assign sram_A    = r_a;
    assign sram_D    = r_d;
    assign sram_CEn  = r_cen;
    assign sram_WEn  = r_wen;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: two instances (plain AW=14, clearing AW=4)
// each with a behavioural SRAM macro and a response scoreboard.
module tb_sram_bus_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    int n_checks = 0;
    int n_errs   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: AW=14, no clear
    logic        a_rst, a_valid, a_ready, a_err, a_busy, a_cen, a_rdy, a_dead;
    logic [31:0] a_addr, a_wdata, a_rdata, a_D, a_wen, a_q;
    logic [3:0]  a_wstrb;
    logic [13:0] a_A;
    logic [31:0] a_mem [0:16383];
    exp_t        a_sb [$];

    // instance C: AW=4, clear on reset
    logic        c_rst, c_valid, c_ready, c_err, c_busy, c_cen, c_rdy;
    logic [31:0] c_addr, c_wdata, c_rdata, c_D, c_wen, c_q;
    logic [3:0]  c_wstrb;
    logic [3:0]  c_A;
    logic [31:0] c_mem [0:15];
    exp_t        c_sb [$];

    sram_bus_ctrl #(.AW(14), .CLEAR_ON_RESET(0), .TIMEOUT(15)) u_dut_a (
        .CLK(clk), .RST(a_rst),
        .mem_valid(a_valid), .mem_ready(a_ready), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_rdata(a_rdata),
        .mem_err(a_err), .clr_busy(a_busy),
        .sram_A(a_A), .sram_D(a_D), .sram_CEn(a_cen), .sram_WEn(a_wen),
        .sram_Q(a_q), .sram_RDY(a_rdy)
    );

    sram_bus_ctrl #(.AW(4), .CLEAR_ON_RESET(1), .TIMEOUT(15)) u_dut_c (
        .CLK(clk), .RST(c_rst),
        .mem_valid(c_valid), .mem_ready(c_ready), .mem_addr(c_addr),
        .mem_wdata(c_wdata), .mem_wstrb(c_wstrb), .mem_rdata(c_rdata),
        .mem_err(c_err), .clr_busy(c_busy),
        .sram_A(c_A), .sram_D(c_D), .sram_CEn(c_cen), .sram_WEn(c_wen),
        .sram_Q(c_q), .sram_RDY(c_rdy)
    );

    // SRAM macros: access on an enabled edge, Q/RDY cleared as CEn rises
    always @(posedge clk or posedge a_cen) begin
        if (a_cen) begin
            a_q   <= '0;
            a_rdy <= 1'b0;
        end else begin
            a_q        <= a_mem[a_A];
            a_rdy      <= !a_dead;
            a_mem[a_A] <= (a_mem[a_A] & a_wen) | (a_D & ~a_wen);
        end
    end

    always @(posedge clk or posedge c_cen) begin
        if (c_cen) begin
            c_q   <= '0;
            c_rdy <= 1'b0;
        end else begin
            c_q        <= c_mem[c_A];
            c_rdy      <= 1'b1;
            c_mem[c_A] <= (c_mem[c_A] & c_wen) | (c_D & ~c_wen);
        end
    end

    // response monitors
    always @(negedge clk) begin
        if (a_ready) begin
            n_checks++;
            if (a_sb.size() == 0) begin
                n_errs++;
                $display("FAIL a_unexpected_ready rdata=%h err=%b", a_rdata, a_err);
            end else begin
                exp_t e;
                e = a_sb.pop_front();
                if (a_err !== e.err || (e.chk && a_rdata !== e.rdata)) begin
                    n_errs++;
                    $display("FAIL a_resp got rdata=%h err=%b want rdata=%h err=%b",
                             a_rdata, a_err, e.rdata, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (c_ready) begin
            n_checks++;
            if (c_sb.size() == 0) begin
                n_errs++;
                $display("FAIL c_unexpected_ready rdata=%h err=%b", c_rdata, c_err);
            end else begin
                exp_t e;
                e = c_sb.pop_front();
                if (c_err !== e.err || (e.chk && c_rdata !== e.rdata)) begin
                    n_errs++;
                    $display("FAIL c_resp got rdata=%h err=%b want rdata=%h err=%b",
                             c_rdata, c_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic a_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_a,
                         input logic [31:0] exp_wen, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat);
        int lat;
        bit got;
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = addr;
        a_wdata = wdata;
        a_wstrb = wstrb;
        a_sb.push_back('{exp_rd, exp_err, (wstrb == 4'b0000)});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("a_cmd_A", 32'(a_A), exp_a);
                chk("a_cmd_WEn", a_wen, exp_wen);
            end
            if (lat == 2 && wstrb != 4'b0000) begin
                chk("a_WEn_restored", a_wen, 32'hFFFF_FFFF);
            end
            got = a_ready;
        end
        a_valid = 1'b0;
        chk("a_latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic c_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rd,
                         input int exp_lat);
        int lat;
        bit got;
        @(negedge clk);
        c_valid = 1'b1;
        c_addr  = addr;
        c_wdata = wdata;
        c_wstrb = wstrb;
        c_sb.push_back('{exp_rd, 1'b0, (wstrb == 4'b0000)});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            got = c_ready;
        end
        c_valid = 1'b0;
        chk("c_latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r1;
        int r2;
        int cyc;
        a_rst = 1'b1; a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        a_dead = 1'b0;
        c_rst = 1'b1; c_valid = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_CEn", 32'(a_cen), 32'd1);
        chk("rst_WEn", a_wen, 32'hFFFF_FFFF);
        chk("rst_A", 32'(a_A), 32'd0);
        chk("rst_D", a_D, 32'd0);
        chk("c_rst_busy", 32'(c_busy), 32'd0);
        chk("c_rst_CEn", 32'(c_cen), 32'd1);
        a_rst = 1'b0;
        c_rst = 1'b0;

        // full write then read
        a_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd4, 32'h0000_0000, 32'h0, 1'b0, 3);
        a_req(32'h0000_0010, 32'h0, 4'h0, 32'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 3);

        // partial-strobe merge
        a_req(32'h0000_0020, 32'hAABB_CCDD, 4'hF, 32'd8, 32'h0000_0000, 32'h0, 1'b0, 3);
        a_req(32'h0000_0020, 32'h1122_3344, 4'b0101, 32'd8, 32'hFF00_FF00, 32'h0, 1'b0, 3);
        a_req(32'h0000_0020, 32'h0, 4'h0, 32'd8, 32'hFFFF_FFFF, 32'hAA22_CC44, 1'b0, 3);

        // high address bits alias onto the same word
        a_req(32'h0001_0010, 32'h0, 4'h0, 32'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 3);

        // dead SRAM: watchdog completes after 15 WAIT cycles
        a_dead = 1'b1;
        a_req(32'h0000_0020, 32'h0, 4'h0, 32'd8, 32'hFFFF_FFFF, 32'h0, 1'b1, 17);
        chk("timeout_CEn", 32'(a_cen), 32'd1);
        chk("timeout_rdata", a_rdata, 32'd0);

        // reset while stuck in WAIT
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 32'h0000_0010;
        a_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        a_rst   = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        chk("wait_rst_CEn", 32'(a_cen), 32'd1);
        chk("wait_rst_ready", 32'(a_ready), 32'd0);
        a_dead = 1'b0;
        a_req(32'h0000_0010, 32'h0, 4'h0, 32'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 3);

        // back-to-back reads with valid held
        a_sb.push_back('{32'hDEAD_BEEF, 1'b0, 1'b1});
        a_sb.push_back('{32'hDEAD_BEEF, 1'b0, 1'b1});
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 32'h0000_0010;
        a_wstrb = 4'h0;
        r1 = 0;
        r2 = 0;
        cyc = 0;
        while (r2 == 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (a_ready) begin
                if (r1 == 0) begin
                    r1 = cyc;
                    a_addr = 32'h0001_0010;
                end else begin
                    r2 = cyc;
                end
            end
        end
        a_valid = 1'b0;
        chk("b2b_first", 32'(r1), 32'd3);
        chk("b2b_gap", 32'(r2 - r1), 32'd4);

        // clearing instance: preload, check, then re-clear
        for (int i = 0; i < 16; i++) begin
            c_req(32'(i * 4), 32'h0000_1000 + 32'(i + 1), 4'hF, 32'h0, 3);
        end
        c_req(32'h0000_0014, 32'h0, 4'h0, 32'h0000_1006, 3);
        @(negedge clk);
        c_rst = 1'b1;
        @(negedge clk);
        c_rst = 1'b0;
        chk("c_clr_rst_busy", 32'(c_busy), 32'd0);
        chk("c_clr_rst_CEn", 32'(c_cen), 32'd1);
        fork
            c_req(32'h0000_0014, 32'h0, 4'h0, 32'h0, 19);
            begin
                int idx;
                idx = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (c_busy) begin
                        chk("c_sweep_A", 32'(c_A), 32'(idx));
                        chk("c_sweep_WEn", c_wen, 32'h0);
                        idx++;
                    end
                end
                chk("c_busy_cycles", 32'(idx), 32'd16);
            end
        join
        for (int i = 0; i < 16; i++) begin
            c_req(32'(i * 4), 32'h0, 4'h0, 32'h0, 3);
        end

        repeat (2) @(negedge clk);
        chk("a_sb_drained", 32'(a_sb.size()), 32'd0);
        chk("c_sb_drained", 32'(c_sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Initiator/controller for the single-port 32-bit SRAM macro interface (Q, D, A, CLK, CEn, WEn, RDY).
- Bridges the picorv32-style native memory bus (valid/ready, byte address, 4-bit write strobe) to the macro's active-low chip enable and per-bit active-low write enable.
- Optional post-reset clear engine zeroes the whole array.
- RDY watchdog reports a missing SRAM response to the bus instead of hanging it.

Parameters:
- AW, 14, SRAM word-address width; DEPTH = 2**AW.
- CLEAR_ON_RESET, 0, when 1, zero all DEPTH words after reset before accepting requests.
- TIMEOUT, 15, maximum cycles spent in WAIT for sram_RDY before forced completion; TIMEOUT >= 2.

Ports:
- CLK  in  1  clock, all logic on posedge
- RST  in  1  synchronous reset, active-high
- mem_valid  in  1  request valid, held until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address; bits [AW+1:2] used, rest ignored (aliasing)
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 = read
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_err  out  1  pulses with mem_ready when the access timed out
- clr_busy  out  1  clear engine running
- sram_A  out  AW  SRAM address
- sram_D  out  32  SRAM write data
- sram_CEn  out  1  SRAM enable, active-low
- sram_WEn  out  32  per-bit write enable, active-low
- sram_Q  in  32  SRAM read data
- sram_RDY  in  1  SRAM access-done flag

Behaviour:
- All outputs registered.
- Reset values:
  - mem_ready=0, mem_rdata=0, mem_err=0, clr_busy=0
  - sram_CEn=1, sram_WEn=32'hFFFF_FFFF, sram_A=0, sram_D=0
  - state=IDLE, or CLR when CLEAR_ON_RESET=1
- Any RST=1 cycle aborts any state; the next edge applies the reset values. The SRAM model clears Q/RDY asynchronously on CEn rising.
- Byte expansion: sram_WEn[8k+7:8k] = {8{~mem_wstrb[k]}}.
- States: CLR, IDLE, CMD, WAIT, RESP.
- CLR:
  - clr_busy=1, sram_CEn=0, sram_WEn=0, sram_D=0.
  - sram_A starts at 0 and increments every edge, one write per cycle.
  - After the edge presenting address DEPTH-1: CEn<=1, WEn<=all-ones, clr_busy<=0, state IDLE.
  - mem_valid is ignored (mem_ready stays 0) for exactly DEPTH+1 cycles after reset release.
- IDLE:
  - Request accepted when mem_valid=1 and mem_ready=0 (blocks re-acceptance in the pulse cycle).
  - Registers sram_A=mem_addr[AW+1:2], sram_D=mem_wdata, sram_WEn per strobe expansion.
  - Sets sram_CEn<=0, latches is_read=(mem_wstrb==0); state CMD.
- CMD: the SRAM performs the access at this edge. Set sram_WEn<=all-ones so the held-enable follow-on edge is a harmless read; clear timeout counter; state WAIT.
- WAIT:
  - sram_RDY=1 sampled: if is_read, mem_rdata<=sram_Q (writes leave mem_rdata unchanged); mem_ready<=1; sram_CEn<=1; state RESP.
  - Otherwise the counter increments. On the edge where it reaches TIMEOUT: mem_rdata<=0, mem_err<=1, mem_ready<=1, sram_CEn<=1; state RESP.
- RESP: mem_ready<=0, mem_err<=0; state IDLE.
- Latency with a responsive SRAM: accept edge E0, mem_ready high in the cycle after E2 (3 cycles valid-to-ready); back-to-back throughput is one access per 4 cycles.
- sram_CEn is never raised while a read result is still needed. Q is captured before CEn rises.
- mem_valid dropping mid-transaction (protocol violation) does not abort; the transaction completes.

Decomposition:
- Shared package sram_ctrl_pkg: state encoding constants (CLR, IDLE, CMD, WAIT, RESP), WEN_NONE=32'hFFFF_FFFF, strobe-to-bit-mask expansion function.
- No sub-module; the optional clear engine is a counter plus state inside this block.

Test Plan:
- Write mem_addr=0x0000_0010, wdata=0xDEADBEEF, wstrb=4'hF, then read 0x10 -> write shows sram_A=4 and sram_WEn=0 for one edge; read returns mem_rdata=0xDEADBEEF with mem_ready exactly 3 cycles after valid.
- Write 0xAABBCCDD wstrb=4'hF, then wdata=0x11223344 wstrb=4'b0101, then read -> WEn=32'hFF00_FF00 on the partial write; read returns 0xAA22CC44.
- CLEAR_ON_RESET=1, AW=4: preload nonzero words, pulse RST -> clr_busy high 16 cycles with sram_A sweeping 0..15; every word then reads 0; mem_valid raised during the clear is accepted only after clr_busy falls.
- Hold sram_RDY forced 0 with TIMEOUT=15 on a read -> mem_ready and mem_err pulse together in the cycle after the 15th WAIT cycle; mem_rdata=0; sram_CEn=1.
- Assert RST for 1 cycle while in WAIT -> next cycle sram_CEn=1, mem_ready=0; the subsequent read completes normally.
- Addresses 0x0001_0010 and 0x0000_0010 with AW=14 -> same sram_A=4 (aliasing); two back-to-back reads show mem_ready pulses 4 cycles apart.
